decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: splits fetch bundles into ALU operands, control flags and branch targets,
// held in a one-entry valid/ready pipeline register in front of execute.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_insn,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [5:0]  alucode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] store_data,
  output logic [4:0]  rd_addr,
  output logic        reg_we,
  output logic        is_load,
  output logic        is_store,
  output logic [31:0] id_pc,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam logic [5:0] ALU_LUI  = 6'd0;
  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6;
  localparam logic [5:0] ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9;
  localparam logic [5:0] ALU_LH   = 6'd10;
  localparam logic [5:0] ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12;
  localparam logic [5:0] ALU_LHU  = 6'd13;
  localparam logic [5:0] ALU_SB   = 6'd14;
  localparam logic [5:0] ALU_SH   = 6'd15;
  localparam logic [5:0] ALU_SW   = 6'd16;
  localparam logic [5:0] ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_SUB  = 6'd18;
  localparam logic [5:0] ALU_SLT  = 6'd19;
  localparam logic [5:0] ALU_SLTU = 6'd20;
  localparam logic [5:0] ALU_XOR  = 6'd21;
  localparam logic [5:0] ALU_OR   = 6'd22;
  localparam logic [5:0] ALU_AND  = 6'd23;
  localparam logic [5:0] ALU_SLL  = 6'd24;
  localparam logic [5:0] ALU_SRL  = 6'd25;
  localparam logic [5:0] ALU_SRA  = 6'd26;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and the payload is stable whenever id_valid is high and ex_ready low.
  logic capture;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] shamt;

  logic [5:0]  d_alucode;
  logic [31:0] d_op1, d_op2, d_store_data, d_br_target;
  logic [4:0]  d_rd_addr;
  logic        d_writes, d_reg_we, d_is_load, d_is_store, d_illegal;

  assign opcode   = if_insn[6:0];
  assign funct3   = if_insn[14:12];
  assign funct7   = if_insn[31:25];
  assign rs1_addr = if_insn[19:15];
  assign rs2_addr = if_insn[24:20];

  assign imm_i = {{20{if_insn[31]}}, if_insn[31:20]};
  assign imm_s = {{20{if_insn[31]}}, if_insn[31:25], if_insn[11:7]};
  assign imm_b = {{19{if_insn[31]}}, if_insn[31], if_insn[7], if_insn[30:25], if_insn[11:8], 1'b0};
  assign imm_u = {if_insn[31:12], 12'h000};
  assign imm_j = {{11{if_insn[31]}}, if_insn[31], if_insn[19:12], if_insn[20], if_insn[30:21], 1'b0};
  assign shamt = {27'd0, if_insn[24:20]};

  assign if_ready = !id_valid || ex_ready;
  assign capture  = if_valid && if_ready && !flush;

  always_comb begin
    d_alucode    = ALU_ADD;
    d_op1        = 32'd0;
    d_op2        = 32'd0;
    d_store_data = 32'd0;
    d_br_target  = 32'd0;
    d_writes     = 1'b0;
    d_is_load    = 1'b0;
    d_is_store   = 1'b0;
    d_illegal    = 1'b0;

    case (opcode)
      OPC_OP: begin
        d_op1    = rs1_data;
        d_op2    = rs2_data;
        d_writes = 1'b1;
        case (funct3)
          3'd0: begin
            if (funct7 == F7_BASE)     d_alucode = ALU_ADD;
            else if (funct7 == F7_ALT) d_alucode = ALU_SUB;
            else                       d_illegal = 1'b1;
          end
          3'd5: begin
            if (funct7 == F7_BASE)     d_alucode = ALU_SRL;
            else if (funct7 == F7_ALT) d_alucode = ALU_SRA;
            else                       d_illegal = 1'b1;
          end
          default: begin
            if (funct7 != F7_BASE) d_illegal = 1'b1;
            case (funct3)
              3'd1:    d_alucode = ALU_SLL;
              3'd2:    d_alucode = ALU_SLT;
              3'd3:    d_alucode = ALU_SLTU;
              3'd4:    d_alucode = ALU_XOR;
              3'd6:    d_alucode = ALU_OR;
              default: d_alucode = ALU_AND;
            endcase
          end
        endcase
      end
      OPC_OP_IMM: begin
        d_op1    = rs1_data;
        d_op2    = imm_i;
        d_writes = 1'b1;
        case (funct3)
          3'd0: d_alucode = ALU_ADD;
          3'd2: d_alucode = ALU_SLT;
          3'd3: d_alucode = ALU_SLTU;
          3'd4: d_alucode = ALU_XOR;
          3'd6: d_alucode = ALU_OR;
          3'd7: d_alucode = ALU_AND;
          3'd1: begin
            d_op2 = shamt;
            if (funct7 == F7_BASE) d_alucode = ALU_SLL;
            else                   d_illegal = 1'b1;
          end
          default: begin
            d_op2 = shamt;
            if (funct7 == F7_BASE)     d_alucode = ALU_SRL;
            else if (funct7 == F7_ALT) d_alucode = ALU_SRA;
            else                       d_illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        d_alucode = ALU_LUI;
        d_op2     = imm_u;
        d_writes  = 1'b1;
      end
      OPC_AUIPC: begin
        d_alucode = ALU_ADD;
        d_op1     = if_pc;
        d_op2     = imm_u;
        d_writes  = 1'b1;
      end
      OPC_JAL: begin
        d_alucode   = ALU_JAL;
        d_op2       = if_pc;
        d_br_target = if_pc + imm_j;
        d_writes    = 1'b1;
      end
      OPC_JALR: begin
        d_alucode   = ALU_JALR;
        d_op1       = rs1_data;
        d_op2       = if_pc;
        d_br_target = (rs1_data + imm_i) & ~32'd1;
        d_writes    = 1'b1;
        if (funct3 != 3'd0) d_illegal = 1'b1;
      end
      OPC_BRANCH: begin
        d_op1       = rs1_data;
        d_op2       = rs2_data;
        d_br_target = if_pc + imm_b;
        case (funct3)
          3'd0:    d_alucode = ALU_BEQ;
          3'd1:    d_alucode = ALU_BNE;
          3'd4:    d_alucode = ALU_BLT;
          3'd5:    d_alucode = ALU_BGE;
          3'd6:    d_alucode = ALU_BLTU;
          3'd7:    d_alucode = ALU_BGEU;
          default: d_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_op1     = rs1_data;
        d_op2     = imm_i;
        d_is_load = 1'b1;
        d_writes  = 1'b1;
        case (funct3)
          3'd0:    d_alucode = ALU_LB;
          3'd1:    d_alucode = ALU_LH;
          3'd2:    d_alucode = ALU_LW;
          3'd4:    d_alucode = ALU_LBU;
          3'd5:    d_alucode = ALU_LHU;
          default: d_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d_op1        = rs1_data;
        d_op2        = imm_s;
        d_store_data = rs2_data;
        d_is_store   = 1'b1;
        case (funct3)
          3'd0:    d_alucode = ALU_SB;
          3'd1:    d_alucode = ALU_SH;
          3'd2:    d_alucode = ALU_SW;
          default: d_illegal = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase

    // An illegal encoding turns into a harmless ADD 0,0 with every side effect suppressed.
    if (d_illegal) begin
      d_alucode    = ALU_ADD;
      d_op1        = 32'd0;
      d_op2        = 32'd0;
      d_store_data = 32'd0;
      d_br_target  = 32'd0;
      d_writes     = 1'b0;
      d_is_load    = 1'b0;
      d_is_store   = 1'b0;
    end
  end

  assign d_rd_addr = d_writes ? if_insn[11:7] : 5'd0;
  assign d_reg_we  = d_writes && (d_rd_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      alucode    <= 6'd0;
      op1        <= 32'd0;
      op2        <= 32'd0;
      store_data <= 32'd0;
      rd_addr    <= 5'd0;
      reg_we     <= 1'b0;
      is_load    <= 1'b0;
      is_store   <= 1'b0;
      id_pc      <= 32'd0;
      br_target  <= 32'd0;
      illegal    <= 1'b0;
    end else begin
      if (flush)         id_valid <= 1'b0;
      else if (capture)  id_valid <= 1'b1;
      else if (ex_ready) id_valid <= 1'b0;

      if (capture) begin
        alucode    <= d_alucode;
        op1        <= d_op1;
        op2        <= d_op2;
        store_data <= d_store_data;
        rd_addr    <= d_rd_addr;
        reg_we     <= d_reg_we;
        is_load    <= d_is_load;
        is_store   <= d_is_store;
        id_pc      <= if_pc;
        br_target  <= d_br_target;
        illegal    <= d_illegal;
      end
    end
  end

endmodule
